fetch_unit: RTL

Instruction-fetch stage that generates the program counter, issues requests to instruction memory over a request/grant and in-order response interface, and buffers returned instructions in a small FIFO. It sits directly upstream of the IF/ID pipeline register and drives that register's instruction and PC inputs every cycle. Branch and jump redirects flush buffered and in-flight fetches. Decode back-pressure holds the stage's outputs stable.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, request/grant issue to instruction
// memory, in-order response tagging and a small output buffer feeding IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        valid
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  // Dropped responses can pile up across back-to-back redirects, so this
  // counter is deliberately wider than the credit counters.
  localparam int DW = 8;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   buf_pc_q    [BUF_DEPTH];
  logic [31:0]   buf_pc_d    [BUF_DEPTH];
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_instr_d [BUF_DEPTH];
  logic [31:0]   tag_q       [BUF_DEPTH];
  logic [31:0]   tag_d       [BUF_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [DW-1:0] drop_q, drop_d;

  logic [CW:0]   inflight_sum;
  logic          req;
  logic          grant;
  logic          resp_take;
  logic          resp_drop;
  logic          pop;

  // Issue/response/pop bookkeeping; redirect overrides everything else.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    drop_d      = drop_q;

    // Credit covers both in-flight and buffered fetches, so the buffer can
    // never overflow. Gating with reset keeps the request low while held.
    inflight_sum = {1'b0, out_q} + {1'b0, cnt_q};
    req          = reset && !redirect && (inflight_sum < (CW+1)'(BUF_DEPTH));
    grant        = req && imem_gnt;
    resp_drop    = imem_rvalid && (drop_q != '0);
    resp_take    = imem_rvalid && (drop_q == '0);
    pop          = (cnt_q != '0) && !stall;

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      cnt_d      = '0;
      out_d      = '0;
      // Everything still owed by memory after this cycle must be discarded;
      // a response arriving now is already accounted for by the subtraction.
      drop_d     = drop_q + DW'(out_q) - DW'(imem_rvalid);
    end else begin
      if (grant) begin
        tag_d[tag_wr_q] = fetch_pc_q;
        tag_wr_d        = tag_wr_q + AW'(1);
        fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (resp_drop) begin
        drop_d = drop_q - DW'(1);
      end
      if (resp_take) begin
        buf_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
        buf_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + AW'(1);
        tag_rd_d              = tag_rd_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      out_d = out_q + CW'(grant) - CW'(resp_take);
      cnt_d = cnt_q + CW'(resp_take) - CW'(pop);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
        tag_q[i]       <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
    end
  end

  // Outputs are a register-only view of the buffer head; bubbles read as zero.
  always_comb begin
    imem_req    = req;
    imem_addr   = fetch_pc_q;
    valid       = (cnt_q != '0);
    instruction = valid ? buf_instr_q[rd_ptr_q] : 32'h0;
    PC          = valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
  end

endmodule
